// File: rtl/simple_cpu_pkg.sv
// Shared definitions for simple_cpu: opcodes, instruction field ranges, ALU select and decode bundle.
// Also holds the branch/jump target helper used by the next-PC logic.
package simple_cpu_pkg;

   localparam logic [7:0] OP_LOADI = 8'd0;
   localparam logic [7:0] OP_MOV   = 8'd1;
   localparam logic [7:0] OP_ADD   = 8'd2;
   localparam logic [7:0] OP_SUB   = 8'd3;
   localparam logic [7:0] OP_AND   = 8'd4;
   localparam logic [7:0] OP_OR    = 8'd5;
   localparam logic [7:0] OP_J     = 8'd6;
   localparam logic [7:0] OP_BEQ   = 8'd7;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 24;
   localparam int RD_HI  = 23;
   localparam int RD_LO  = 16;
   localparam int RS1_HI = 15;
   localparam int RS1_LO = 8;
   localparam int RS2_HI = 7;
   localparam int RS2_LO = 0;

   typedef enum logic [1:0] {
      ALU_FWD = 2'd0,
      ALU_ADD = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_sel_e;

   typedef struct packed {
      logic     wen;
      alu_sel_e sel;
      logic     sub;
      logic     use_imm;
      logic     jump;
      logic     beq;
   } dec_t;

   // Offset counts 32-bit words; the sum wraps modulo 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [7:0] off);
      return pc + 32'd4 + {{22{off[7]}}, off, 2'b00};
   endfunction

endpackage

// File: rtl/simple_cpu_reg_file.sv
// 2-read/1-write register file; reads are combinational and see the pre-write value in a write cycle.
// SIM_DELAYS_EN adds #2 on reads and #1 on writes; reset clears every entry asynchronously.
module simple_cpu_reg_file
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [AW-1:0]     ra_addr_i,
   input  logic [AW-1:0]     rb_addr_i,
   output logic [DATA_W-1:0] ra_data_o,
   output logic [DATA_W-1:0] rb_data_o,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
`ifdef SIM_DELAYS_EN
         regs_q[waddr_i] <= #1 wdata_i;
`else
         regs_q[waddr_i] <= wdata_i;
`endif
      end
   end

`ifdef SIM_DELAYS_EN
   assign #2 ra_data_o = regs_q[ra_addr_i];
   assign #2 rb_data_o = regs_q[rb_addr_i];
`else
   assign ra_data_o = regs_q[ra_addr_i];
   assign rb_data_o = regs_q[rb_addr_i];
`endif

endmodule

// File: rtl/simple_cpu.sv
// Single-cycle 8-bit CPU: instruction at PC is decoded and executed in one cycle, PC and writeback on rising clk.
// Build macro SIM_DELAYS_EN inserts the lab's fixed simulation delays; undefined gives zero-delay RTL.
module simple_cpu
   import simple_cpu_pkg::*;
#(
   parameter int          DATA_W   = 8,
   parameter int          NUM_REGS = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   output logic [31:0] PC,
   input  logic [31:0] inst,
   input  logic        clk,
   input  logic        reset
);

   localparam int AW = $clog2(NUM_REGS);

   logic [31:0]       pc_q;
   logic [31:0]       pc_d;
   logic [7:0]        opcode;
   logic [7:0]        f_rd;
   logic [7:0]        f_rs1;
   logic [7:0]        f_rs2;
   logic [AW-1:0]     rd_addr;
   logic [AW-1:0]     rs1_addr;
   logic [AW-1:0]     rs2_addr;
   dec_t              dec_raw;
   dec_t              dec;
   logic [DATA_W-1:0] rf_a;
   logic [DATA_W-1:0] rf_b;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] b_eff;
   logic [DATA_W-1:0] alu_raw;
   logic [DATA_W-1:0] alu_res;
   logic              zero;
   logic              take_br;
   logic [31:0]       pc_plus4_raw;
   logic [31:0]       pc_plus4;
   logic [31:0]       br_tgt_raw;
   logic [31:0]       br_tgt;
   logic              unused_rs1_hi;

   assign opcode   = inst[OPC_HI:OPC_LO];
   assign f_rd     = inst[RD_HI:RD_LO];
   assign f_rs1    = inst[RS1_HI:RS1_LO];
   assign f_rs2    = inst[RS2_HI:RS2_LO];
   assign rd_addr  = f_rd[AW-1:0];
   assign rs1_addr = f_rs1[AW-1:0];
   assign rs2_addr = f_rs2[AW-1:0];

   assign unused_rs1_hi = ^f_rs1[7:AW];

   always_comb begin
      dec_raw = '0;
      case (opcode)
         OP_LOADI: begin
            dec_raw.wen     = 1'b1;
            dec_raw.use_imm = 1'b1;
         end
         OP_MOV: begin
            dec_raw.wen = 1'b1;
         end
         OP_ADD: begin
            dec_raw.wen = 1'b1;
            dec_raw.sel = ALU_ADD;
         end
         OP_SUB: begin
            dec_raw.wen = 1'b1;
            dec_raw.sel = ALU_ADD;
            dec_raw.sub = 1'b1;
         end
         OP_AND: begin
            dec_raw.wen = 1'b1;
            dec_raw.sel = ALU_AND;
         end
         OP_OR: begin
            dec_raw.wen = 1'b1;
            dec_raw.sel = ALU_OR;
         end
         OP_J: begin
            dec_raw.jump = 1'b1;
         end
         OP_BEQ: begin
            dec_raw.sel = ALU_ADD;
            dec_raw.sub = 1'b1;
            dec_raw.beq = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef SIM_DELAYS_EN
   assign #1 dec = dec_raw;
`else
   assign dec = dec_raw;
`endif

   simple_cpu_reg_file #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_rf (
      .clk_i     (clk),
      .rst_i     (reset),
      .ra_addr_i (rs1_addr),
      .rb_addr_i (rs2_addr),
      .ra_data_o (rf_a),
      .rb_data_o (rf_b),
      .we_i      (dec.wen),
      .waddr_i   (rd_addr),
      .wdata_i   (alu_res)
   );

   assign op_b = dec.use_imm ? DATA_W'(f_rs2) : rf_b;

   // Subtraction is a + ~b + 1 so beq can reuse the adder's zero result.
   always_comb begin
      b_eff   = dec.sub ? ~op_b : op_b;
      alu_raw = op_b;
      case (dec.sel)
         ALU_FWD: alu_raw = op_b;
         ALU_ADD: alu_raw = rf_a + b_eff + DATA_W'(dec.sub);
         ALU_AND: alu_raw = rf_a & op_b;
         ALU_OR:  alu_raw = rf_a | op_b;
         default: alu_raw = op_b;
      endcase
   end

`ifdef SIM_DELAYS_EN
   logic [DATA_W-1:0] alu_fast;
   logic [DATA_W-1:0] alu_slow;
   assign #1 alu_fast = alu_raw;
   assign #2 alu_slow = alu_raw;
   assign alu_res = (dec.sel == ALU_ADD) ? alu_slow : alu_fast;
`else
   assign alu_res = alu_raw;
`endif

   assign zero = (alu_res == '0);

   assign pc_plus4_raw = pc_q + 32'd4;
   assign br_tgt_raw   = branch_target(pc_q, f_rd);

`ifdef SIM_DELAYS_EN
   assign #1 pc_plus4 = pc_plus4_raw;
   assign #2 br_tgt   = br_tgt_raw;
`else
   assign pc_plus4 = pc_plus4_raw;
   assign br_tgt   = br_tgt_raw;
`endif

   assign take_br = dec.jump | (dec.beq & zero);
   assign pc_d    = take_br ? br_tgt : pc_plus4;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
`ifdef SIM_DELAYS_EN
         pc_q <= #1 pc_d;
`else
         pc_q <= pc_d;
`endif
      end
   end

   assign PC = pc_q;

endmodule

// File: tb/tb_simple_cpu.sv
// Directed bench for simple_cpu: behavioural instruction memory, PC trace and register-file probes.
module tb_simple_cpu;

   logic        clk;
   logic        reset;
   logic [31:0] PC;
   logic [31:0] inst;

   logic [31:0] imem [16];
   int          n_cmp;
   int          n_err;

   logic [31:0] trace [15] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28,
                               32'd32, 32'd20, 32'd24, 32'd28, 32'd40, 32'd44, 32'd48};

   simple_cpu dut (
      .PC    (PC),
      .inst  (inst),
      .clk   (clk),
      .reset (reset)
   );

   assign inst = (PC < 32'd64) ? imem[PC[5:2]] : 32'h0800_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input int idx, input logic [7:0] exp);
      check(tag, {24'h0, dut.u_rf.regs_q[idx]}, {24'h0, exp});
   endtask

   // exp packs {r7,...,r0}.
   task automatic check_regs(input string tag, input logic [63:0] exp);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_r%0d", tag, i), {24'h0, dut.u_rf.regs_q[i]}, {24'h0, exp[8*i +: 8]});
      end
   endtask

   task automatic step(input string tag, input logic [31:0] exp_pc);
      @(posedge clk);
      #1;
      check(tag, PC, exp_pc);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) imem[i] = 32'h0800_0000;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;

      clear_mem();
      imem[0]  = 32'h0001_0003;
      imem[1]  = 32'h0004_0001;
      imem[2]  = 32'h0002_0005;
      imem[3]  = 32'h0003_0003;
      imem[4]  = 32'h0205_0203;
      imem[5]  = 32'h0301_0104;
      imem[6]  = 32'h0106_0001;
      imem[7]  = 32'h0702_0401;
      imem[8]  = 32'h06FC_0000;
      imem[9]  = 32'h0001_0003;
      imem[10] = 32'h0004_0001;
      imem[11] = 32'h0002_0005;
      imem[12] = 32'h0003_0003;

      // Reset raised mid-cycle while the clock runs.
      #12 reset = 1'b1;
      #1;
      check("rst_pc_async", PC, 32'h0);
      check_regs("rst_regs", 64'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("loop_pc0", PC, trace[0]);

      for (int i = 1; i < 15; i++) begin
         step($sformatf("loop_pc%0d", i), trace[i]);
         if (i == 4) begin
            check_reg("loadi_r1", 1, 8'd3);
            check_reg("loadi_r4", 4, 8'd1);
            check_reg("loadi_r2", 2, 8'd5);
            check_reg("loadi_r3", 3, 8'd3);
         end
         if (i == 5) check_reg("add_r5", 5, 8'd8);
         if (i == 6) check_reg("sub_r1", 1, 8'd2);
         if (i == 7) check_reg("mov_r6", 6, 8'd2);
         if (i == 10) check_reg("sub2_r1", 1, 8'd1);
         if (i == 12) check_reg("mov2_r6", 6, 8'd1);
      end
      check_regs("loop_end", 64'h0001_0801_0305_0100);

      // Reset after a loadi mid-loop: everything clears at once and the pending write is dropped.
      #2 reset = 1'b1;
      #1;
      check("midrst_pc", PC, 32'h0);
      check_regs("midrst_regs", 64'h0);
      @(posedge clk);
      #1;
      check("midrst_hold_pc", PC, 32'h0);
      check_reg("midrst_hold_r1", 1, 8'd0);

      clear_mem();
      imem[0] = 32'h0002_00F0;
      imem[1] = 32'h0003_003C;
      imem[2] = 32'h0404_0203;
      imem[3] = 32'h0505_0203;
      imem[4] = 32'h0006_0000;
      imem[5] = 32'h0007_0001;
      imem[6] = 32'h0301_0607;
      imem[7] = 32'h0801_0203;
      imem[8] = 32'h0009_0011;
      imem[9] = 32'h0680_0000;

      @(negedge clk);
      reset = 1'b0;
      #1;
      check("p2_pc0", PC, 32'h0);
      step("p2_pc4", 32'd4);
      check_reg("p2_loadi_r2", 2, 8'hF0);
      step("p2_pc8", 32'd8);
      check_reg("p2_loadi_r3", 3, 8'h3C);
      step("p2_pc12", 32'd12);
      check_reg("and_r4", 4, 8'h30);
      step("p2_pc16", 32'd16);
      check_reg("or_r5", 5, 8'hFC);
      step("p2_pc20", 32'd20);
      step("p2_pc24", 32'd24);
      check_reg("p2_loadi_r7", 7, 8'h01);
      step("p2_pc28", 32'd28);
      check_reg("sub_wrap_r1", 1, 8'hFF);
      step("nop_pc", 32'd32);
      check_regs("nop_regs", 64'h0100_FC30_3CF0_FF00);
      step("p2_pc36", 32'd36);
      check_reg("idx_wrap_r1", 1, 8'h11);
      check_reg("idx_wrap_r7", 7, 8'h01);
      step("j_neg_wrap_pc", 32'hFFFF_FE28);
      step("after_wrap_pc", 32'hFFFF_FE2C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/simple_cpu.md
Name: simple_cpu

Overview:
- Single-cycle 8-bit-datapath CPU with a 32-bit instruction word and a 32-bit byte-addressed PC.
- Top-level processor of the simple-processor lab. Drives PC to an external instruction memory and receives the instruction combinationally on inst.
- Contains an 8x8-bit register file, an 8-bit ALU, a decoder, and next-PC logic for jump and branch-if-equal.

Parameters:
- DATA_W, 8, datapath and register width.
- NUM_REGS, 8, register-file depth; register index = low 3 bits of the field.
- RESET_PC, 32'h0, PC value while and after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- PC  output  32  byte address of the current instruction.
- inst  input  32  instruction fetched at PC; valid within the same cycle.
- Declaration order for positional instantiation: PC, inst, clk, reset.

Behaviour:
- One clock; reset is asynchronous and active-high.
- While reset is high: PC=RESET_PC and all registers are 0. The first fetch is at 0 after release.
- Instruction fields:
  - [31:24] opcode.
  - [23:16] dest register, or signed 8-bit word offset for j/beq.
  - [15:8] src1 register.
  - [7:0] src2 register, or 8-bit immediate.
- Opcodes and operations:
  - 0 loadi: rd = imm.
  - 1 mov: rd = r[src2].
  - 2 add: rd = r[src1] + r[src2].
  - 3 sub: rd = r[src1] - r[src2].
  - 4 and: rd = r[src1] & r[src2].
  - 5 or: rd = r[src1] | r[src2].
  - 6 j: no writeback; PC = PC + 4 + sext(offset)*4.
  - 7 beq: no writeback; if r[src1]==r[src2], PC = PC + 4 + sext(offset)*4, else PC + 4.
- Arithmetic: 8-bit modulo 2^8. sub is src1 + ~src2 + 1. beq equality uses the ALU zero flag of the subtraction.
- Opcodes 8..255: no-op, no writeback, PC+4.
- Register file:
  - Two asynchronous read ports.
  - One write port, written on rising clk when the write enable is set.
  - A read of a register being written in the same cycle returns the old value.
- PC update: registered on rising clk to next-PC. Sequential next-PC = PC+4.
- Branch/jump offsets wrap modulo 2^32.
- Reset mid-operation: PC and registers clear immediately. An in-flight writeback is discarded.

Optional Feature:
- SIM_DELAYS_EN defined: inserts the lab's fixed simulation delays.
  - PC register update #1.
  - Decode #1.
  - Register read #2.
  - Register write #1.
  - ALU #1 for mov/loadi/and/or, #2 for add/sub.
  - PC adder #1, branch/jump adder #2.
  - Functional results at each clock edge are identical, given a clock period ≥ 10 units and memory latency ≤ 2.
- Undefined: zero-delay RTL.

Decomposition:
- Package simple_cpu_pkg holds:
  - opcode constants OP_LOADI..OP_BEQ.
  - instruction field bit ranges.
  - ALU-select enum (FWD, ADD, AND, OR).
- One sub-module, simple_cpu_reg_file: 8x8 registers, 2R1W, asynchronous reset clearing all registers.
- ALU and decoder stay inline.

Test Plan:
- Reset pulse mid-cycle with clk running -> PC=0 immediately. First instruction fetched at 0; PC advances 0,4,8,... on subsequent edges.
- loadi r1=3, r4=1, r2=5, r3=3 -> registers read back 3,1,5,3 via hierarchical probe of the reg file.
- add r5 = r2 + r3 -> r5=8. sub r1 = r1 - r4 -> 2. mov r6 = r1 -> 6 holds 2.
- Loop program, 13 words:
  - Encoded as 00010003, 00040001, 00020005, 00030003, 02050203, 03010104, 01060001, 07020401, 06FC0000, then repeats of the first four.
  - Required PC trace: 0,4,8,12,16,20,24,28,32,20,24,28,40,44,48.
  - beq not taken with r1=2; j offset -4 goes to 20; beq taken with r1=1 goes to 40.
- and/or with r2=0xF0, r3=0x3C -> and gives 0x30, or gives 0xFC. sub 0x00-0x01 gives 0xFF (wrap).
- Unknown opcode 0x08 -> no register change, PC+4. Reset asserted after a loadi mid-loop -> all registers 0, PC 0.
